// File: rtl/io_bus_master.sv
// io_bus_master: turns one host request into a strobed word-bus cycle,
// waits on the responder's dtack and converts a silent bus into berr.
module io_bus_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter bit          IDLE_RW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_be,
  input  logic [22:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        berr,
  output logic [15:0] rdata,
  output logic [22:0] ad,
  output logic        as,
  output logic        rw,
  output logic        uds,
  output logic        lds,
  output logic [15:0] od,
  input  logic        dtack,
  input  logic        dv,
  input  logic [15:0] id
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_NULL
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    be_q, be_d;
  logic          pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          berr_q, berr_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [22:0]   ad_q, ad_d;
  logic          as_q, as_d;
  logic          rw_q, rw_d;
  logic          uds_q, uds_d;
  logic          lds_q, lds_d;
  logic [15:0]   od_q, od_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      be_q    <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      berr_q  <= 1'b0;
      rdata_q <= 16'hFFFF;
      ad_q    <= '0;
      as_q    <= 1'b0;
      rw_q    <= IDLE_RW;
      uds_q   <= 1'b0;
      lds_q   <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      be_q    <= be_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      berr_q  <= berr_d;
      rdata_q <= rdata_d;
      ad_q    <= ad_d;
      as_q    <= as_d;
      rw_q    <= rw_d;
      uds_q   <= uds_d;
      lds_q   <= lds_d;
      od_q    <= od_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    be_d    = be_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    berr_d  = 1'b0;
    rdata_d = rdata_q;
    ad_d    = ad_q;
    as_d    = as_q;
    rw_d    = rw_q;
    uds_d   = uds_q;
    lds_d   = lds_q;
    od_d    = od_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          busy_d = 1'b1;
          if (req_be != 2'b00) begin
            be_d    = req_be;
            ad_d    = req_addr;
            rw_d    = req_we;
            od_d    = req_wdata;
            state_d = S_SETUP;
          end else begin
            state_d = S_NULL;
          end
        end
      end
      S_NULL: begin
        done_d  = 1'b1;
        berr_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_SETUP: begin
        as_d    = 1'b1;
        uds_d   = be_q[1];
        lds_d   = be_q[0];
        timer_d = '0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        // dtack is checked first so it wins over a same-edge timeout
        if (dtack) begin
          if (!rw_q) rdata_d = dv ? id : 16'hFFFF;
          as_d    = 1'b0;
          uds_d   = 1'b0;
          lds_d   = 1'b0;
          pend_d  = 1'b0;
          timer_d = '0;
          state_d = S_RELEASE;
        end else if (timer_q == TLAST) begin
          as_d    = 1'b0;
          uds_d   = 1'b0;
          lds_d   = 1'b0;
          pend_d  = 1'b1;
          timer_d = '0;
          state_d = S_RELEASE;
        end else if (timer_q != TMAX) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RELEASE: begin
        if (!dtack || timer_q == TLAST) begin
          done_d  = 1'b1;
          berr_d  = dtack ? 1'b1 : pend_q;
          busy_d  = 1'b0;
          rw_d    = IDLE_RW;
          state_d = S_IDLE;
        end else if (timer_q != TMAX) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign berr  = berr_q;
  assign rdata = rdata_q;
  assign ad    = ad_q;
  assign as    = as_q;
  assign rw    = rw_q;
  assign uds   = uds_q;
  assign lds   = lds_q;
  assign od    = od_q;

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: random and directed bus cycles against a responder,
// scored by a queue-based monitor using a transaction-level model.
module tb_io_bus_master;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_be = 2'b00;
  logic [22:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        busy, done, berr, as, rw, uds, lds;
  logic [15:0] rdata, od;
  logic [22:0] ad;
  logic        dtack = 1'b0;
  logic        dv = 1'b0;
  logic [15:0] id = '0;

  io_bus_master #(.TIMEOUT(TO), .IDLE_RW(1'b0)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .berr(berr), .rdata(rdata),
    .ad(ad), .as(as), .rw(rw), .uds(uds), .lds(lds), .od(od),
    .dtack(dtack), .dv(dv), .id(id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic        berr;
    logic [15:0] rdata;
    int          lat;
    int          as_n;
    int          acc;
  } exp_t;

  exp_t sq[$];
  int   dq[$];
  int   checks = 0;
  int   passes = 0;
  bit   in_rst = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 16'h1F3 + 16'h5A);
  endfunction

  // Region 101 is unmapped, 110 holds dtack long after the strobes drop,
  // addr[19] set means the responder never asserts dv.
  logic [15:0] rmem [16];
  logic        rinit = 1'b0;
  int          hold = 0;
  always @(posedge clk) begin
    if (!rinit) begin
      for (int i = 0; i < 16; i++) rmem[i] <= init_word(i);
      rinit <= 1'b1;
    end
    if (as && ad[22:20] != 3'b101) begin
      if (!dtack) begin
        if (rw && uds) rmem[ad[3:0]][15:8] <= od[15:8];
        if (rw && lds) rmem[ad[3:0]][7:0] <= od[7:0];
        id <= {uds ? rmem[ad[3:0]][15:8] : 8'hFF,
               lds ? rmem[ad[3:0]][7:0] : 8'hFF};
        dv <= !rw && !ad[19];
      end
      dtack <= 1'b1;
      hold  <= (ad[22:20] == 3'b110) ? 20 : 0;
    end else if (hold > 0) begin
      hold <= hold - 1;
      dv   <= 1'b0;
    end else begin
      dtack <= 1'b0;
      dv    <= 1'b0;
    end
  end

  logic [15:0] mmem [16];
  logic [15:0] mrd = 16'hFFFF;

  function automatic exp_t model(input logic we, input logic [1:0] be,
                                 input logic [22:0] a,
                                 input logic [15:0] wd);
    exp_t e;
    int ix;
    logic [15:0] w;
    ix = int'(a[3:0]);
    e.we = we; e.be = be; e.addr = a; e.wdata = wd;
    e.berr = 1'b0; e.lat = 5; e.as_n = 2; e.acc = 0;
    if (be == 2'b00) begin
      e.berr = 1'b1; e.lat = 1; e.as_n = 0;
    end else if (a[22:20] == 3'b101) begin
      e.berr = 1'b1; e.lat = TO + 2; e.as_n = TO;
    end else begin
      if (a[22:20] == 3'b110) begin
        e.berr = 1'b1; e.lat = TO + 3;
      end
      if (we) begin
        if (be[1]) mmem[ix][15:8] = wd[15:8];
        if (be[0]) mmem[ix][7:0] = wd[7:0];
      end else begin
        w = mmem[ix];
        mrd = a[19] ? 16'hFFFF :
              {be[1] ? w[15:8] : 8'hFF, be[0] ? w[7:0] : 8'hFF};
      end
    end
    e.rdata = mrd;
    return e;
  endfunction

  int   as_cnt = 0;
  bit   pbad = 1'b0;
  exp_t me;
  always @(posedge clk) begin
    #1;
    if (in_rst) begin
      as_cnt = 0;
      pbad = 1'b0;
    end else begin
      if ((uds || lds) && !as) pbad = 1'b1;
      if (as) begin
        as_cnt++;
        if (sq.size() == 0) pbad = 1'b1;
        else if (ad !== sq[0].addr || rw !== sq[0].we ||
                 uds !== sq[0].be[1] || lds !== sq[0].be[0] ||
                 (sq[0].we && od !== sq[0].wdata)) pbad = 1'b1;
      end
      if (done) begin
        dq.push_back(cyc);
        if (sq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: done=1 with no request pending (cycle %0d)", cyc);
        end else begin
          me = sq.pop_front();
          chk("berr", 32'(berr), 32'(me.berr));
          chk("rdata", 32'(rdata), 32'(me.rdata));
          chk("latency", 32'(cyc - me.acc), 32'(me.lat));
          chk("as_cycles", 32'(as_cnt), 32'(me.as_n));
          chk("bus_phase", 32'(pbad), 32'd0);
          chk("rw_idle", 32'(rw), 32'd0);
          chk("busy_at_done", 32'(busy), 32'd0);
        end
        as_cnt = 0;
        pbad = 1'b0;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] be,
                       input logic [22:0] a, input logic [15:0] wd,
                       input bit keep);
    int n;
    exp_t e;
    n = 0;
    while ((busy || dtack) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      checks++;
      $display("FAIL idle_wait: busy=%0b dtack=%0b after %0d cycles", busy, dtack, n);
    end
    req = 1'b1; req_we = we; req_be = be;
    req_addr = a; req_wdata = wd;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!busy && n < 50);
    if (!busy) begin
      checks++;
      $display("FAIL accept: busy=%0b expected 1 after %0d cycles", busy, n);
      req = 1'b0;
      return;
    end
    e = model(we, be, a, wd);
    e.acc = cyc;
    sq.push_back(e);
    if (!keep) req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sq.size() > 0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (sq.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d outstanding, expected 0", sq.size());
      sq.delete();
    end
  endtask

  localparam logic [22:0] A_MAP  = 23'h400003;
  localparam logic [22:0] A_UNM  = 23'h500000;
  localparam logic [22:0] A_STK  = 23'h600005;
  localparam logic [22:0] A_NODV = 23'h480007;

  initial begin
    int n;
    bit saw;
    logic [2:0] rg;
    logic [1:0] be;
    logic [22:0] a;
    for (int i = 0; i < 16; i++) mmem[i] = init_word(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_berr", 32'(berr), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'hFFFF);
    chk("rst_ad", 32'(ad), 32'd0);
    chk("rst_as", 32'(as), 32'd0);
    chk("rst_strobes", 32'({uds, lds}), 32'd0);
    chk("rst_rw", 32'(rw), 32'd0);
    chk("rst_od", 32'(od), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    in_rst = 1'b0;

    issue(1'b0, 2'b01, A_MAP, 16'h0000, 1'b0);
    issue(1'b1, 2'b01, A_MAP, 16'h00C3, 1'b0);
    issue(1'b0, 2'b11, A_MAP, 16'h0000, 1'b0);
    issue(1'b0, 2'b11, A_UNM, 16'h0000, 1'b0);
    issue(1'b1, 2'b00, A_MAP, 16'h1234, 1'b0);
    issue(1'b0, 2'b10, A_STK, 16'h0000, 1'b0);
    issue(1'b0, 2'b11, A_NODV, 16'h0000, 1'b0);
    drain();

    issue(1'b0, 2'b11, A_MAP, 16'h0000, 1'b0);
    n = 0;
    while (!as && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("abort_as_seen", 32'(as), 32'd1);
    reset = 1'b1;
    in_rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_as", 32'(as), 32'd0);
    chk("abort_strobes", 32'({uds, lds}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    sq.delete();
    mrd = 16'hFFFF;
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    chk("abort_no_done", 32'(saw), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'hFFFF);
    in_rst = 1'b0;
    issue(1'b0, 2'b11, 23'h400004, 16'h0000, 1'b0);
    drain();

    dq.delete();
    for (int i = 0; i < 3; i++)
      issue(1'b0, 2'b11, 23'(23'h400000 + i * 2), 16'h0000, 1'b1);
    req = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_count", 32'(dq.size()), 32'd3);
    if (dq.size() == 3) begin
      chk("b2b_gap0", 32'(dq[1] - dq[0]), 32'd6);
      chk("b2b_gap1", 32'(dq[2] - dq[1]), 32'd6);
    end

    for (int t = 0; t < 60; t++) begin
      n = int'($urandom_range(0, 9));
      if (n == 0) rg = 3'b101;
      else if (n == 1) rg = 3'b110;
      else rg = 3'($urandom_range(0, 4));
      be = 2'($urandom_range(0, 3));
      a = {rg, 1'($urandom_range(0, 1)), 15'd0, 4'($urandom_range(0, 15))};
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue(1'($urandom_range(0, 1)), be, a, 16'($urandom), 1'b0);
    end
    drain();
    repeat (30) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
    $fatal(1);
  end

endmodule
